branch_predict_ctrl: RTL and testbench

//  Dynamic branch prediction controller for the 5-stage RISC-V pipeline. Fetch side: predicts

---
 rtl/branch_predict_ctrl.sv | 173 +++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: direct-mapped BHT/BTB lookup at fetch, training,
// misprediction detection and one-cycle redirect/flush sequencing at execute.
module branch_predict_ctrl #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [31:0]       iPCF,
    input  logic [31:0]       iInstructionF,
    output logic              oPredTakenF,
    output logic [31:0]       oPredTargetF,
    input  logic              iBranchE,
    input  logic [31:0]       iPCE,
    input  logic              iPredTakenE,
    input  logic [31:0]       iPredTargetE,
    input  logic              iTakenE,
    input  logic [31:0]       iTargetE,
    output logic              oRedirect,
    output logic [31:0]       oRedirectPC,
    output logic              oFlushD,
    output logic              oFlushE,
    output logic [CNT_W-1:0]  oBranchCount,
    output logic [CNT_W-1:0]  oMispredCount
);

    localparam int         ENTRIES    = 2 ** IDX_BITS;
    localparam int         TAG_W      = 32 - IDX_BITS - 2;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t              state_q;
    state_t              state_d;

    logic                valid_q [ENTRIES];
    logic [TAG_W-1:0]    tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];
    logic [1:0]          ctr_q   [ENTRIES];

    logic [CNT_W-1:0]    br_cnt_q;
    logic [CNT_W-1:0]    br_cnt_d;
    logic [CNT_W-1:0]    mis_cnt_q;
    logic [CNT_W-1:0]    mis_cnt_d;
    logic [1:0]          ctr_d;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11) begin
            r = c + 2'd1;
        end else if (!up && c != 2'b00) begin
            r = c - 2'd1;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&c) ? c : c + one;
    endfunction

    // Fetch-side lookup: purely combinational, reads pre-edge table contents
    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                is_branch_f;
    logic                hit_f;
    logic signed [31:0]  imm_b_f;

    assign idx_f       = iPCF[IDX_BITS+1:2];
    assign tag_f       = iPCF[31:IDX_BITS+2];
    assign is_branch_f = (iInstructionF[6:0] == OPC_BRANCH);
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign imm_b_f     = {{19{iInstructionF[31]}}, iInstructionF[31], iInstructionF[7],
                          iInstructionF[30:25], iInstructionF[11:8], 1'b0};

    always_comb begin
        oPredTakenF  = 1'b0;
        oPredTargetF = 32'h0;
        if (is_branch_f) begin
            if (hit_f) begin
                oPredTakenF  = ctr_q[idx_f][1];
                oPredTargetF = tgt_q[idx_f];
            end else begin
                // Static fallback: backward branches (negative offset) predicted taken
                oPredTakenF  = iInstructionF[31];
                oPredTargetF = iPCF + $unsigned(imm_b_f);
            end
        end
    end

    // Execute-side resolution
    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_W-1:0]    tag_e;
    logic                hit_e;
    logic                mispredict_e;
    logic                upd_e;

    assign idx_e        = iPCE[IDX_BITS+1:2];
    assign tag_e        = iPCE[31:IDX_BITS+2];
    assign hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign mispredict_e = iBranchE && ((iPredTakenE != iTakenE) ||
                                       (iTakenE && (iPredTargetE != iTargetE)));
    // In RECOVER the execute stage holds a squashed bubble, so it must not train
    assign upd_e        = iBranchE && (state_q == IDLE);

    assign oRedirect   = iRstN && (state_q == IDLE) && mispredict_e;
    assign oFlushD     = oRedirect;
    assign oFlushE     = oRedirect;
    assign oRedirectPC = iTakenE ? iTargetE : (iPCE + 32'd4);

    assign oBranchCount  = br_cnt_q;
    assign oMispredCount = mis_cnt_q;

    always_comb begin
        state_d   = IDLE;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        ctr_d     = iTakenE ? 2'b10 : 2'b01;
        if (state_q == IDLE && mispredict_e) begin
            state_d = RECOVER;
        end
        if (upd_e) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (mispredict_e) begin
                mis_cnt_d = sat_inc(mis_cnt_q);
            end
            if (hit_e) begin
                ctr_d = ctr_step(ctr_q[idx_e], iTakenE);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // A miss overwrites the slot unconditionally; a hit only retrains counter and target
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_e) begin
            valid_q[idx_e] <= 1'b1;
            tag_q[idx_e]   <= tag_e;
            tgt_q[idx_e]   <= iTargetE;
            ctr_q[idx_e]   <= ctr_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iPCF[1:0], iPCE[1:0], iInstructionF[24:12]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed-vector bench for branch_predict_ctrl: a default instance plus a CNT_W=4
// instance for statistics-counter saturation.
module tb_branch_predict_ctrl;

    localparam logic [31:0] BEQ_BACK = 32'hFE000EE3; // beq, imm = -4
    localparam logic [31:0] BEQ_FWD  = 32'h00000463; // beq, imm = +8
    localparam logic [31:0] ADDI     = 32'h00000013;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f, ins_f, ptgt_e, pc_e, tgt_e;
    logic        br_e, pt_e, tk_e;
    logic        pred_tk_f, redir, flush_d, flush_e;
    logic [31:0] pred_tgt_f, redir_pc;
    logic [15:0] br_cnt, mis_cnt;

    logic [31:0] s_pc_f, s_ins_f, s_ptgt_e, s_pc_e, s_tgt_e;
    logic        s_br_e, s_pt_e, s_tk_e;
    logic        s_pred_tk_f, s_redir, s_flush_d, s_flush_e;
    logic [31:0] s_pred_tgt_f, s_redir_pc;
    logic [3:0]  s_br_cnt, s_mis_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    branch_predict_ctrl #(.IDX_BITS(4), .CNT_W(16)) dut (
        .iClk(clk), .iRstN(rst_n), .iPCF(pc_f), .iInstructionF(ins_f),
        .oPredTakenF(pred_tk_f), .oPredTargetF(pred_tgt_f),
        .iBranchE(br_e), .iPCE(pc_e), .iPredTakenE(pt_e), .iPredTargetE(ptgt_e),
        .iTakenE(tk_e), .iTargetE(tgt_e), .oRedirect(redir), .oRedirectPC(redir_pc),
        .oFlushD(flush_d), .oFlushE(flush_e), .oBranchCount(br_cnt), .oMispredCount(mis_cnt)
    );

    branch_predict_ctrl #(.IDX_BITS(4), .CNT_W(4)) dut_small (
        .iClk(clk), .iRstN(rst_n), .iPCF(s_pc_f), .iInstructionF(s_ins_f),
        .oPredTakenF(s_pred_tk_f), .oPredTargetF(s_pred_tgt_f),
        .iBranchE(s_br_e), .iPCE(s_pc_e), .iPredTakenE(s_pt_e), .iPredTargetE(s_ptgt_e),
        .iTakenE(s_tk_e), .iTargetE(s_tgt_e), .oRedirect(s_redir), .oRedirectPC(s_redir_pc),
        .oFlushD(s_flush_d), .oFlushE(s_flush_e), .oBranchCount(s_br_cnt),
        .oMispredCount(s_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        pc_f  = pc;
        ins_f = ins;
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           input logic tk, input logic [31:0] tgt);
        br_e   = 1'b1;
        pc_e   = pc;
        pt_e   = pt;
        ptgt_e = ptgt;
        tk_e   = tk;
        tgt_e  = tgt;
        #1;
    endtask

    task automatic no_branch();
        br_e = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        br_e = 1'b0; pc_e = '0; pt_e = 1'b0; ptgt_e = '0; tk_e = 1'b0; tgt_e = '0;
        pc_f = '0; ins_f = '0;
        s_br_e = 1'b0; s_pc_e = 32'h400; s_pt_e = 1'b1; s_ptgt_e = 32'h500;
        s_tk_e = 1'b1; s_tgt_e = 32'h500; s_pc_f = '0; s_ins_f = ADDI;

        // T1: reset state and static rule
        fetch(32'h100, BEQ_BACK);
        check_val("rst_redirect", redir, 0);
        check_val("rst_flushd", flush_d, 0);
        check_val("rst_flushe", flush_e, 0);
        check_val("rst_brcnt", br_cnt, 0);
        check_val("rst_miscnt", mis_cnt, 0);
        check_val("t1_back_taken", pred_tk_f, 1);
        check_val("t1_back_target", pred_tgt_f, 32'h0FC);
        fetch(32'h104, BEQ_FWD);
        check_val("t1_fwd_taken", pred_tk_f, 0);
        check_val("t1_fwd_target", pred_tgt_f, 32'h10C);
        fetch(32'h108, ADDI);
        check_val("t1_nonbr_taken", pred_tk_f, 0);
        check_val("t1_nonbr_target", pred_tgt_f, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T2: mispredict in IDLE, same-cycle redirect; fetch of same index sees old table
        resolve(32'h200, 1'b0, 32'h0, 1'b1, 32'h240);
        fetch(32'h200, BEQ_FWD);
        check_val("t2_redirect", redir, 1);
        check_val("t2_redirect_pc", redir_pc, 32'h240);
        check_val("t2_flushd", flush_d, 1);
        check_val("t2_flushe", flush_e, 1);
        check_val("t2_nobypass_taken", pred_tk_f, 0);
        check_val("t2_nobypass_target", pred_tgt_f, 32'h208);
        tick();

        // T4: RECOVER ignores a resolving branch
        resolve(32'h200, 1'b1, 32'h240, 1'b0, 32'h280);
        check_val("t2_rec_redirect", redir, 0);
        check_val("t2_rec_flushd", flush_d, 0);
        check_val("t2_rec_flushe", flush_e, 0);
        check_val("t2_brcnt", br_cnt, 1);
        check_val("t2_miscnt", mis_cnt, 1);
        tick();
        no_branch();
        fetch(32'h200, BEQ_FWD);
        check_val("t4_brcnt", br_cnt, 1);
        check_val("t4_miscnt", mis_cnt, 1);
        check_val("t4_hit_taken", pred_tk_f, 1);
        check_val("t4_hit_target", pred_tgt_f, 32'h240);
        fetch(32'h200, ADDI);
        check_val("t4_nonbr_hit_taken", pred_tk_f, 0);
        check_val("t4_nonbr_hit_target", pred_tgt_f, 32'h0);

        // T3: counter training 10 -> 11 (sat) -> down to 00 (sat) -> up again
        for (int i = 0; i < 3; i++) begin
            resolve(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);
            check_val("t3_taken_noredirect", redir, 0);
            tick();
        end
        resolve(32'h200, 1'b0, 32'h0, 1'b0, 32'h240);
        check_val("t3_nt_noredirect", redir, 0);
        tick();
        no_branch();
        fetch(32'h200, BEQ_FWD);
        check_val("t3_ctr10_taken", pred_tk_f, 1);
        check_val("t3_ctr10_target", pred_tgt_f, 32'h240);
        check_val("t3_brcnt", br_cnt, 5);
        check_val("t3_miscnt", mis_cnt, 1);
        resolve(32'h200, 1'b0, 32'h0, 1'b0, 32'h240);
        tick();
        no_branch();
        check_val("t3_ctr01_taken", pred_tk_f, 0);
        for (int i = 0; i < 2; i++) begin
            resolve(32'h200, 1'b0, 32'h0, 1'b0, 32'h240);
            tick();
        end
        resolve(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);
        tick();
        no_branch();
        check_val("t3_ctr00_up_taken", pred_tk_f, 0);
        resolve(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);
        tick();
        no_branch();
        check_val("t3_ctr10_again_taken", pred_tk_f, 1);
        check_val("t3_brcnt_10", br_cnt, 10);

        // T5: aliasing PCs 0x200 / 0x240 share index 0
        resolve(32'h240, 1'b1, 32'h300, 1'b1, 32'h300);
        fetch(32'h240, BEQ_FWD);
        check_val("t5_pre_alloc_target", pred_tgt_f, 32'h248);
        tick();
        no_branch();
        fetch(32'h200, BEQ_FWD);
        check_val("t5_evicted_taken", pred_tk_f, 0);
        check_val("t5_evicted_target", pred_tgt_f, 32'h208);
        fetch(32'h240, BEQ_FWD);
        check_val("t5_alloc_taken", pred_tk_f, 1);
        check_val("t5_alloc_target", pred_tgt_f, 32'h300);
        resolve(32'h200, 1'b0, 32'h0, 1'b0, 32'h240);
        tick();
        no_branch();
        fetch(32'h200, BEQ_FWD);
        check_val("t5_realloc_taken", pred_tk_f, 0);
        check_val("t5_realloc_target", pred_tgt_f, 32'h240);
        fetch(32'h240, BEQ_FWD);
        check_val("t5_static_target", pred_tgt_f, 32'h248);

        // Target-only mispredict, then not-taken mispredict (fall-through PC)
        resolve(32'h240, 1'b1, 32'h111, 1'b1, 32'h300);
        check_val("tgt_mis_redirect", redir, 1);
        check_val("tgt_mis_pc", redir_pc, 32'h300);
        tick();
        no_branch();
        check_val("tgt_mis_rec_redirect", redir, 0);
        tick();
        resolve(32'h240, 1'b1, 32'h300, 1'b0, 32'h300);
        check_val("nt_mis_redirect", redir, 1);
        check_val("nt_mis_pc", redir_pc, 32'h244);
        check_val("nt_mis_flushe", flush_e, 1);
        tick();

        // T6: async reset while in RECOVER
        no_branch();
        fetch(32'h240, BEQ_FWD);
        check_val("t6_pre_brcnt", br_cnt, 14);
        check_val("t6_pre_miscnt", mis_cnt, 3);
        check_val("t6_pre_hit_target", pred_tgt_f, 32'h300);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_brcnt", br_cnt, 0);
        check_val("t6_rst_miscnt", mis_cnt, 0);
        check_val("t6_rst_static_taken", pred_tk_f, 0);
        check_val("t6_rst_static_target", pred_tgt_f, 32'h248);
        resolve(32'h200, 1'b0, 32'h0, 1'b1, 32'h240);
        check_val("t6_rst_redirect_gated", redir, 0);
        rst_n = 1'b1;
        #1;
        check_val("t6_idle_redirect", redir, 1);
        check_val("t6_idle_pc", redir_pc, 32'h240);
        tick();
        no_branch();
        check_val("t6_post_brcnt", br_cnt, 1);
        check_val("t6_post_miscnt", mis_cnt, 1);
        tick();

        // CNT_W=4 instance: branch and mispredict counters saturate at 4'hF
        s_br_e = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) check_val("sat_brcnt_15", s_br_cnt, 4'hF);
        end
        check_val("sat_brcnt_20", s_br_cnt, 4'hF);
        check_val("sat_miscnt_0", s_mis_cnt, 4'h0);
        s_pt_e = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_br_e = 1'b1;
            tick();
            s_br_e = 1'b0;
            tick();
        end
        check_val("sat_miscnt_17", s_mis_cnt, 4'hF);
        check_val("sat_brcnt_hold", s_br_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
